// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants for the processor control unit
package proc_pkg;

    localparam int NREG = 8;
    localparam int IR_W = 16;

    localparam int IR_OP_HI = 15;
    localparam int IR_OP_LO = 13;
    localparam int IR_X_HI  = 12;
    localparam int IR_X_LO  = 10;
    localparam int IR_Y_HI  = 9;
    localparam int IR_Y_LO  = 7;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } tstep_t;

endpackage

// File: rtl/proc_ctrl_if.sv
// rtl/proc_ctrl_if.sv - control-to-datapath signal bundle; Gnz exists only with PROC_CTRL_MVNZ_EN
interface proc_ctrl_if #(
    parameter int NREG = 8,
    parameter int IR_W = 16
);
    logic            Run;
    logic [IR_W-1:0] IR;
`ifdef PROC_CTRL_MVNZ_EN
    logic            Gnz;
`endif
    logic            IRin;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic            DINout;
    logic            Ain;
    logic            Gin;
    logic            Gout;
    logic            AddSub;
    logic            Busy;
    logic            Done;

`ifdef PROC_CTRL_MVNZ_EN
    modport master (
        input  Run, IR, Gnz,
        output IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Busy, Done
    );
    modport slave (
        output Run, IR, Gnz,
        input  IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Busy, Done
    );
`else
    modport master (
        input  Run, IR,
        output IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Busy, Done
    );
    modport slave (
        output Run, IR,
        input  IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Busy, Done
    );
`endif
endinterface

// File: rtl/dec3to8.sv
// rtl/dec3to8.sv - 3-to-8 one-hot decoder with enable
module dec3to8 (
    input  logic [2:0] i_w,
    input  logic       i_en,
    output logic [7:0] o_y
);
    always_comb begin
        o_y = '0;
        if (i_en) begin
            o_y[i_w] = 1'b1;
        end
    end
endmodule

// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - T0..T3 sequencer and instruction decoder; PROC_CTRL_MVNZ_EN adds conditional move (opcode 100)
module proc_ctrl
    import proc_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    proc_ctrl_if.master bus
);
    tstep_t     r_state;
    logic [2:0] w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [7:0] w_xsel;
    logic [7:0] w_ysel;
    logic       w_ir_unused;
    logic       w_is_alu;

    assign w_op        = bus.IR[IR_OP_HI:IR_OP_LO];
    assign w_x         = bus.IR[IR_X_HI:IR_X_LO];
    assign w_y         = bus.IR[IR_Y_HI:IR_Y_LO];
    assign w_ir_unused = ^bus.IR[IR_Y_LO-1:0];
    assign w_is_alu    = (w_op == OP_ADD) || (w_op == OP_SUB);

    dec3to8 u_dec_x (.i_w(w_x), .i_en(1'b1), .o_y(w_xsel));
    dec3to8 u_dec_y (.i_w(w_y), .i_en(1'b1), .o_y(w_ysel));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= T0;
        end else begin
            unique case (r_state)
                T0:      r_state <= bus.Run ? T1 : T0;
                T1:      r_state <= w_is_alu ? T2 : T0;
                T2:      r_state <= T3;
                default: r_state <= T0;
            endcase
        end
    end

    // IRin is the only output that is non-zero in T0, so gating it alone keeps outputs quiet in reset.
    always_comb begin
        bus.IRin   = 1'b0;
        bus.Rin    = '0;
        bus.Rout   = '0;
        bus.DINout = 1'b0;
        bus.Ain    = 1'b0;
        bus.Gin    = 1'b0;
        bus.Gout   = 1'b0;
        bus.AddSub = 1'b0;
        bus.Busy   = (r_state != T0);
        bus.Done   = 1'b0;
        unique case (r_state)
            T0: bus.IRin = bus.Run & Resetn;
            T1: begin
                unique case (w_op)
                    OP_MV: begin
                        bus.Rout = w_ysel;
                        bus.Rin  = w_xsel;
                        bus.Done = 1'b1;
                    end
                    OP_MVI: begin
                        bus.DINout = 1'b1;
                        bus.Rin    = w_xsel;
                        bus.Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.Rout = w_xsel;
                        bus.Ain  = 1'b1;
                    end
`ifdef PROC_CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        if (bus.Gnz) begin
                            bus.Rout = w_ysel;
                            bus.Rin  = w_xsel;
                        end
                        bus.Done = 1'b1;
                    end
`endif
                    default: bus.Done = 1'b1;
                endcase
            end
            T2: begin
                bus.Rout   = w_ysel;
                bus.Gin    = 1'b1;
                bus.AddSub = (w_op == OP_SUB);
            end
            default: begin
                bus.Gout = 1'b1;
                bus.Rin  = w_xsel;
                bus.Done = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_proc_ctrl.sv
// tb/tb_proc_ctrl.sv - scoreboard bench for proc_ctrl; honours PROC_CTRL_MVNZ_EN
module tb_proc_ctrl;
    logic        clk;
    logic        rst_n;
    logic [15:0] ir_q;
    logic [15:0] ir_next;
    logic [23:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    proc_ctrl_if bus ();

    proc_ctrl dut (
        .Clock (clk),
        .Resetn(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath IR register, loaded when the controller asserts IRin.
    always @(posedge clk) begin
        if (bus.IRin) ir_q <= ir_next;
    end
    assign bus.IR = ir_q;

    function automatic logic [23:0] vec(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                        input logic din, input logic ain, input logic gin, input logic gout,
                                        input logic addsub, input logic busy, input logic done);
        return {irin, rin, rout, din, ain, gin, gout, addsub, busy, done};
    endfunction

    function automatic logic [23:0] sample();
        return {bus.IRin, bus.Rin, bus.Rout, bus.DINout, bus.Ain, bus.Gin, bus.Gout,
                bus.AddSub, bus.Busy, bus.Done};
    endfunction

    task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
        end
    endtask

    // Called at a negedge in T0; returns at the negedge following Done.
    task automatic issue(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                         input logic gnz, input logic run_after);
        logic [7:0] xs;
        logic [7:0] ys;
        int         n;
        xs = 8'h01 << x;
        ys = 8'h01 << y;
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        case (op)
            3'b000: exp_q.push_back(vec(0, xs, ys, 0, 0, 0, 0, 0, 1, 1));
            3'b001: exp_q.push_back(vec(0, xs, 0, 1, 0, 0, 0, 0, 1, 1));
            3'b010, 3'b011: begin
                exp_q.push_back(vec(0, 0, xs, 0, 1, 0, 0, 0, 1, 0));
                exp_q.push_back(vec(0, 0, ys, 0, 0, 1, 0, op[0], 1, 0));
                exp_q.push_back(vec(0, xs, 0, 0, 0, 0, 1, 0, 1, 1));
            end
`ifdef PROC_CTRL_MVNZ_EN
            3'b100: exp_q.push_back(gnz ? vec(0, xs, ys, 0, 0, 0, 0, 0, 1, 1)
                                        : vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
`endif
            default: exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        endcase
        bus.Run = 1'b1;
        ir_next = {op, x, y, 7'($urandom_range(0, 127))};
`ifdef PROC_CTRL_MVNZ_EN
        bus.Gnz = gnz;
`endif
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            #1 check_eq($sformatf("op%0d_x%0d_y%0d_c%0d", op, x, y, i), sample(), exp_q.pop_front());
            @(negedge clk);
            if (i == 0) bus.Run = run_after;
        end
        bus.Run = run_after;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.Run  = 1'b1;
        ir_q     = 16'h0;
        ir_next  = 16'h0;
`ifdef PROC_CTRL_MVNZ_EN
        bus.Gnz  = 1'b0;
`endif
        @(negedge clk);
        #1 check_eq("reset_outputs", sample(), 24'h0);
        @(negedge clk);
        bus.Run = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < 10; i++) begin
            #1 check_eq($sformatf("idle_c%0d", i), sample(), 24'h0);
            @(negedge clk);
        end

        issue(3'b001, 3'd3, 3'd0, 1'b0, 1'b0);
        issue(3'b000, 3'd5, 3'd3, 1'b0, 1'b0);
        issue(3'b010, 3'd0, 3'd1, 1'b0, 1'b0);
        issue(3'b011, 3'd4, 3'd6, 1'b0, 1'b1);
        issue(3'b010, 3'd2, 3'd2, 1'b0, 1'b1);
        issue(3'b000, 3'd7, 3'd7, 1'b0, 1'b1);
        issue(3'b111, 3'd1, 3'd2, 1'b0, 1'b0);
        issue(3'b101, 3'd6, 3'd5, 1'b0, 1'b0);
        issue(3'b100, 3'd2, 3'd6, 1'b0, 1'b0);
        issue(3'b100, 3'd1, 3'd3, 1'b1, 1'b0);
        issue(3'b011, 3'd7, 3'd0, 1'b0, 1'b0);

        // Abort an add in T2: outputs drop at once and no write follows release.
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(vec(0, 0, 8'h04, 0, 1, 0, 0, 0, 1, 0));
        exp_q.push_back(vec(0, 0, 8'h08, 0, 0, 1, 0, 0, 1, 0));
        bus.Run = 1'b1;
        ir_next = {3'b010, 3'd2, 3'd3, 7'h00};
        for (int i = 0; i < 3; i++) begin
            #1 check_eq($sformatf("abort_c%0d", i), sample(), exp_q.pop_front());
            if (i < 2) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1 check_eq("abort_reset_zero", sample(), 24'h0);
        @(negedge clk);
        bus.Run = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("abort_after_c%0d", i), sample(), 24'h0);
            @(negedge clk);
        end

        issue(3'b001, 3'd6, 3'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1);
    end
endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Control unit that sequences the simple processor datapath: eight registers R0–R7, accumulator A, adder/subtractor output register G and a shared 16-bit bus.
- Holds the time-step state machine (T0–T3) and decodes the instruction register.
- Drives every register-enable, every bus-select and the ALU mode signal.
- Sits between IR/Run and the datapath; raises Done when each instruction completes.

Parameters:
- NREG, 8, number of general registers; width of Rin/Rout; X/Y fields are log2(NREG) = 3 bits.
- IR_W, 16, instruction register width. Instruction field is IR[15:7]: opcode IR[15:13], X IR[12:10], Y IR[9:7]. IR[6:0] is ignored.

Ports:
- Clock   in   1      rising-edge clock
- Resetn  in   1      asynchronous, active-low reset
- Run     in   1      start request, sampled in T0
- IR      in   IR_W   instruction register contents, loaded by IRin
- IRin    out  1      IR load enable
- Rin     out  NREG   one-hot register write enables
- Rout    out  NREG   one-hot register bus drives
- DINout  out  1      DIN drives bus (immediate)
- Ain     out  1      A load enable
- Gin     out  1      G load enable
- Gout    out  1      G drives bus
- AddSub  out  1      0 = add, 1 = subtract
- Busy    out  1      high in T1..T3
- Done    out  1      final cycle of an instruction

Behaviour:
- State: 2-bit time step; encodings T0=00, T1=01, T2=10, T3=11. All outputs are combinational from state, IR and Run.
- Reset: Resetn low forces T0 immediately, independent of Clock. During reset all outputs are 0. Reset in T1–T3 aborts the instruction; no Rin/Gin/Ain pulse follows.
- T0: IRin = Run; all other outputs 0.
  - Run=1 → T1 next edge, and IR loads at that same edge.
  - Run=0 → stay in T0.
- Opcodes:
  - 000 mv: T1 Rout[Y], Rin[X], Done → T0.
  - 001 mvi: T1 DINout, Rin[X], Done → T0.
  - 010 add: T1 Rout[X], Ain → T2; T2 Rout[Y], Gin, AddSub=0 → T3; T3 Gout, Rin[X], Done → T0.
  - 011 sub: same as add, but AddSub=1 in T2.
  - 100–111 (unless the optional feature enables 100): NOP; T1 Done only → T0.
- Latency (Run sampled high to Done):
  - mv / mvi / NOP: 1 cycle.
  - add / sub: 3 cycles.
  - Back-to-back: Run held high issues the next fetch in the cycle after Done.
- Bus exclusivity: in any cycle at most one of {Rout bits, DINout, Gout} is asserted. Rin is at most one-hot.
- X==Y is legal: mv is a no-op write; add doubles the value.
- Run is ignored in T1–T3.
- Busy = (state != T0).
- Done is asserted for exactly one cycle per instruction.

Optional Feature:
- Macro: PROC_CTRL_MVNZ_EN.
- Defined:
  - Adds input port Gnz (1 bit, G != 0, supplied by the datapath).
  - Opcode 100 is mvnz: T1 asserts Rout[Y] and Rin[X] only if Gnz=1; Done is asserted regardless → T0.
- Undefined: no Gnz port; opcode 100 is a NOP.

Decomposition:
- Shared package proc_pkg holds:
  - Opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ.
  - Time-step encodings T0..T3.
  - IR field bit positions.
- Sub-module: the existing dec3to8 is instantiated twice (X and Y fields, enable tied high) to produce one-hot X/Y selects. No other hierarchy.

Test Plan:
- Reset: Resetn=0 asserted mid-T2 of an add → next sample shows all outputs 0, state T0; no Rin pulse follows release.
- mvi then mv: IR=001_011_xxx, Run=1 → T1 DINout=1, Rin=8'h08, Done=1. Then IR=000_101_011 → T1 Rout=8'h08, Rin=8'h20, Done.
- add R0,R1: IR=010_000_001 →
  - T1 Rout=8'h01, Ain=1.
  - T2 Rout=8'h02, Gin=1, AddSub=0.
  - T3 Gout=1, Rin=8'h01, Done=1; Busy high for 3 cycles.
- sub, back-to-back: sub with AddSub=1 only in T2, then Run held high → IRin=1 in the cycle after Done and the next instruction starts without an idle cycle.
- NOP/illegal: IR opcode 111 → Done in T1, no enable asserted. Run=0 in T0 → state holds for 10 cycles with IRin=0.
- MVNZ_EN: opcode 100, Gnz=0 → Done with Rin=0. With Gnz=1 → Rin[X] and Rout[Y] asserted. Build without the macro → opcode 100 behaves as NOP.
